// File: rtl/trend_pred_pkg.sv
// Shared constants for the trend predictor table: init entry, step sizes,
// indexing mode encodings and clear-sweep FSM states.
package trend_pred_pkg;

    localparam int          INIT_CNT   = -1;
    localparam logic        INIT_TREND = 1'b0;

    localparam int unsigned STEP_AGREE    = 2;
    localparam int unsigned STEP_DISAGREE = 1;

    localparam int unsigned MODE_BIMODAL = 0;
    localparam int unsigned MODE_GSHARE  = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/trend_step_unit.sv
// Combinational trend-counter step: accelerated step when the outcome repeats
// the stored trend, result saturated to the signed counter range.
module trend_step_unit
    import trend_pred_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             trend_i,
    input  logic             taken_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             trend_o
);

    localparam int unsigned EXT_W = CNT_W + 1;
    localparam logic signed [EXT_W-1:0] CNT_MAX = EXT_W'((2 ** (CNT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] CNT_MIN = EXT_W'(-(2 ** (CNT_W - 1)));

    logic signed [EXT_W-1:0] ext_s;
    logic signed [EXT_W-1:0] step_s;
    logic signed [EXT_W-1:0] sum_s;

    // One extra bit of headroom so the raw sum can never wrap before clamping
    always_comb begin
        ext_s  = {cnt_i[CNT_W-1], cnt_i};
        step_s = (taken_i == trend_i) ? EXT_W'(STEP_AGREE) : EXT_W'(STEP_DISAGREE);
        sum_s  = taken_i ? (ext_s + step_s) : (ext_s - step_s);
        if (sum_s > CNT_MAX) begin
            cnt_o = CNT_MAX[CNT_W-1:0];
        end else if (sum_s < CNT_MIN) begin
            cnt_o = CNT_MIN[CNT_W-1:0];
        end else begin
            cnt_o = sum_s[CNT_W-1:0];
        end
        trend_o = taken_i;
    end

endmodule

// File: rtl/trend_predictor_table.sv
// Trend-counter branch direction table with bimodal/gshare indexing,
// same-edge update bypass and a DEPTH-cycle clear sweep.
module trend_predictor_table
    import trend_pred_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned CONF_T = 2,
    parameter int unsigned HIST_W = 6,
    parameter int unsigned MODE   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_out_valid,
    output logic             pred_taken,
    output logic             pred_confident,
    output logic             pred_trend,
    output logic [IDX_W-1:0] pred_index,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_taken,
    input  logic             clear_req,
    output logic             ready
);

    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam logic signed [CNT_W-1:0] CONF_HI = CNT_W'(CONF_T);
    localparam logic signed [CNT_W-1:0] CONF_LO = CNT_W'(-int'(CONF_T) - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic [CNT_W-1:0]  cnt_q   [DEPTH];
    logic [CNT_W-1:0]  cnt_d   [DEPTH];
    logic              trend_q [DEPTH];
    logic              trend_d [DEPTH];

    logic              pred_out_valid_q, pred_out_valid_d;
    logic              pred_taken_q, pred_taken_d;
    logic              pred_confident_q, pred_confident_d;
    logic              pred_trend_q, pred_trend_d;
    logic [IDX_W-1:0]  pred_index_q, pred_index_d;
    logic              ready_q, ready_d;

    logic                    upd_en;
    logic [IDX_W-1:0]        pred_idx;
    logic [CNT_W-1:0]        new_cnt;
    logic                    new_trend;
    logic signed [CNT_W-1:0] rd_cnt_s;
    logic                    rd_trend;
    logic                    unused_pc;

    assign unused_pc = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

    trend_step_unit #(
        .CNT_W (CNT_W)
    ) u_step (
        .cnt_i   (cnt_q[upd_index]),
        .trend_i (trend_q[upd_index]),
        .taken_i (upd_taken),
        .cnt_o   (new_cnt),
        .trend_o (new_trend)
    );

    // Index uses the pre-shift history; a same-edge update to that entry is bypassed
    always_comb begin
        upd_en   = upd_valid && (state_q == ST_IDLE);
        pred_idx = pred_pc[IDX_W+1:2]
                 ^ ((MODE == MODE_GSHARE) ? IDX_W'(ghr_q) : IDX_W'(0));
        rd_cnt_s = cnt_q[pred_idx];
        rd_trend = trend_q[pred_idx];
        if (upd_en && (upd_index == pred_idx)) begin
            rd_cnt_s = new_cnt;
            rd_trend = new_trend;
        end
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        ghr_d            = ghr_q;
        cnt_d            = cnt_q;
        trend_d          = trend_q;
        pred_out_valid_d = 1'b0;
        pred_taken_d     = pred_taken_q;
        pred_confident_d = pred_confident_q;
        pred_trend_d     = pred_trend_q;
        pred_index_d     = pred_index_q;

        if (upd_en) begin
            cnt_d[upd_index]   = new_cnt;
            trend_d[upd_index] = new_trend;
            ghr_d              = HIST_W'({ghr_q, upd_taken});
        end

        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    ghr_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d[ptr_q]   = CNT_W'(INIT_CNT);
                trend_d[ptr_q] = INIT_TREND;
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pred_valid) begin
            pred_out_valid_d = 1'b1;
            pred_index_d     = pred_idx;
            if (state_q == ST_CLEAR) begin
                pred_taken_d     = 1'b0;
                pred_confident_d = 1'b0;
                pred_trend_d     = 1'b0;
            end else begin
                pred_taken_d     = (rd_cnt_s >= 0);
                pred_confident_d = (rd_cnt_s >= CONF_HI) || (rd_cnt_s <= CONF_LO);
                pred_trend_d     = rd_trend;
            end
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            ptr_q            <= '0;
            ghr_q            <= '0;
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_confident_q <= 1'b0;
            pred_trend_q     <= 1'b0;
            pred_index_q     <= '0;
            ready_q          <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                cnt_q[i]   <= CNT_W'(INIT_CNT);
                trend_q[i] <= INIT_TREND;
            end
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            ghr_q            <= ghr_d;
            pred_out_valid_q <= pred_out_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_confident_q <= pred_confident_d;
            pred_trend_q     <= pred_trend_d;
            pred_index_q     <= pred_index_d;
            ready_q          <= ready_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                cnt_q[i]   <= cnt_d[i];
                trend_q[i] <= trend_d[i];
            end
        end
    end

    assign pred_out_valid = pred_out_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_confident = pred_confident_q;
    assign pred_trend     = pred_trend_q;
    assign pred_index     = pred_index_q;
    assign ready          = ready_q;

endmodule

// File: doc/trend_predictor_table.md
# trend_predictor_table

Parametrised table of trend counters for conditional-branch direction prediction, sitting between the fetch stage (prediction port) and the execute/commit stage (update port). Each entry is a signed saturating counter plus a last-direction trend flag; steps accelerate when the outcome repeats the trend. Indexing is bimodal or gshare (PC XOR global history). A synchronous clear FSM sweeps the table on request, for example on context switch.

## Interface
Parameters:
- XLEN, 32, PC width
- IDX_W, 6, index width; DEPTH = 2^IDX_W entries
- CNT_W, 3, signed counter width (≥2)
- CONF_T, 2, confidence threshold (1 ≤ CONF_T ≤ 2^(CNT_W-1)-1)
- HIST_W, 6, global history length (≤ IDX_W)
- MODE, 1, 0 = bimodal, 1 = gshare

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pred_valid  in  1  prediction request
- pred_pc  in  XLEN  branch PC
- pred_out_valid  out  1  result valid, one cycle after request
- pred_taken  out  1  predicted direction
- pred_confident  out  1  high-confidence flag
- pred_trend  out  1  stored trend flag (1 = up/taken)
- pred_index  out  IDX_W  index used; carried down the pipe for update
- upd_valid  in  1  resolved-branch update
- upd_index  in  IDX_W  entry to update
- upd_taken  in  1  actual outcome
- clear_req  in  1  one-cycle pulse; start a table sweep
- ready  out  1  0 while sweeping

## Operation
- Entry = {cnt[CNT_W-1:0] signed, trend}. Init/clear value: cnt = -1, trend = 0.
- Index = pred_pc[IDX_W+1:2] XOR (MODE ? zero-extended ghr : 0).
- taken = (cnt ≥ 0). confident = (cnt ≥ CONF_T) or (cnt ≤ -CONF_T-1).
- Update: step = 2 if upd_taken == trend, otherwise 1. The new cnt is cnt ± step, computed in CNT_W+1 bits and then clamped to [-2^(CNT_W-1), 2^(CNT_W-1)-1]. The new trend is upd_taken.
- ghr[HIST_W-1:0]: on every accepted update, ghr ← {ghr[HIST_W-2:0], upd_taken}. It is reset and cleared to 0.
- FSM states:
  - IDLE: ready = 1. clear_req moves to CLEAR with ptr = 0.
  - CLEAR: writes the init value to entry ptr each cycle. ptr = DEPTH-1 returns to IDLE. clear_req is ignored while in CLEAR.
- In CLEAR, updates are dropped and the GHR is frozen (already 0). Prediction requests still return, with taken = 0, confident = 0, trend = 0.
- Async reset: all entries to the init value, ghr = 0, FSM IDLE, ptr = 0. All outputs are 0 except ready = 1.

## Timing
- Prediction latency is 1 cycle. All outputs are registered and sampled at the edge where pred_valid = 1. pred_out_valid = 0 in cycles without a request; the other outputs hold their last value.
- Updates take effect at the edge where upd_valid = 1.
- Same-edge prediction and update:
  - Index computation uses the GHR value before that edge's shift.
  - If the computed index equals upd_index, the result reflects the post-update entry (bypass).
- clear_req at edge E: ready = 0 from E+1. The sweep occupies DEPTH cycles. ready = 1 again DEPTH cycles after E+1.
- clear_req and upd_valid at the same IDLE edge: the update is applied, then the sweep begins.
- Reset mid-sweep aborts the sweep and applies the full reset state.

## Structure
- Shared package/header trend_pred_pkg holds:
  - the init-entry constant
  - the step constants (STEP_AGREE = 2, STEP_DISAGREE = 1)
  - the MODE encodings
  - the FSM state encodings
- Sub-module trend_step_unit: combinational, parametrised by CNT_W. It takes {cnt, trend, taken} and produces the new entry with saturation. It is instantiated once for the update path; the same output feeds the bypass.

## Test plan
- Reset, then predict any PC → pred_out_valid = 1 next cycle, taken = 0, confident = 0, trend = 0.
- Bimodal (MODE = 0), index 5, cnt = -1: four taken updates give cnt 0 (step 1), then 2 (step 2, confident = 1), then 3 (saturated), then 3 (still saturated). The prediction reads taken = 1, confident = 1.
- From cnt = 3, trend = 1: not-taken updates give 2, 0, -2, -4. Confident is 1 only at 2 and -4; taken = 0 from -2 onward.
- Same-edge prediction and update on index 7, cnt = -1, upd_taken = 1 → the prediction returns taken = 1, trend = 1 (bypass).
- MODE = 1: updates 1, 0, 1 give ghr = 0b000101. pred_pc = 0x14 (pc bits = 5) → pred_index = 0 (5 XOR 5).
- Train several entries, pulse clear_req → ready = 0 for 64 cycles. An update during the sweep is dropped. Afterwards, every index predicts cnt = -1 behaviour and ghr = 0.
